posit_decode_pipe: RTL and testbench
====================================

// Module: posit_decode_pipe
// PURPOSE
//  Streaming posit-to-PIF decoder: the producer side of the PIF operand bus consumed by the ops stage.
//  Accepts N-bit posit words on a valid/ready stream and emits packed {sign, te, mant} PIF words.
//  Two-stage pipeline with zero/NaR flags; one decoder instance per operand (pif1, pif2).
// PARAMETERS
//  N   16  posit width in bits
//  ES  1   exponent field width
// PORTS
//  clk          in   1         clock; all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  in_valid     in   1         in_posit valid
//  in_ready     out  1         decoder accepts in_posit this cycle
//  in_posit     in   N         raw posit word
//  out_valid    out  1         out_* valid
//  out_ready    in   1         downstream accepts
//  out_pif      out  PIF_SIZE  {sign, te (signed, TE_SIZE), mant (MANT_SIZE)}
//  out_is_zero  out  1         input was 0x0
//  out_is_nar   out  1         input was NaR (1 followed by zeros)
// BEHAVIOUR
//  - Widths: TE_SIZE = ES + clog2(N) + 1; MANT_SIZE = N - 2; PIF_SIZE = 1 + TE_SIZE + MANT_SIZE.
//  - Reset: out_valid=0, stage valids=0, out_pif=0, flags=0; in_ready=1 on the first cycle after rst deasserts.
//  - Reset mid-stream: all in-flight words are dropped; nothing emitted afterwards until new input.
//  - Handshake: advance = !out_valid | out_ready; in_ready = advance; a transfer occurs when valid & ready are both high.
//  - Under stall (out_valid & !out_ready): out_* held bit-stable, no input accepted; order always preserved.
//  - Latency: 2 cycles from accepted input to out_valid when unstalled; throughput 1 word/cycle.
//  - S1: sign = in_posit[N-1]; abs = sign ? -in_posit : in_posit (two's complement); detect zero/NaR.
//  - S2: regime run length r of bits equal to abs[N-2] from abs[N-2] downwards (via lzc).
//      k = abs[N-2] ? r-1 : -r.
//      exp = the next ES bits after the terminator; missing LSBs are read as 0.
//      te = k*2^ES + exp.
//      mant = {1'b1, remaining frac bits left-aligned, zero padded}.
//  - Run reaching bit 0 (no terminator): r = N-1; no exponent or fraction bits.
//  - Zero / NaR: out_pif = 0, the corresponding flag = 1; the sign bit of NaR is not propagated.
//  - Flags are mutually exclusive; both are 0 for normal values.
// CONFIGURATION
//  - Macro PPU_DECODE_STATS_EN.
//  - Defined: adds ports stat_count out 16 and stat_nar out 16.
//      Counts words transferred on the output handshake (total, and those with out_is_nar).
//      Counters saturate at 0xFFFF, reset to 0 on rst, and hold their value during stall.
//  - Undefined: no stat ports, no counter flops; datapath is identical.
// STRUCTURE
//  - Package ppu_pkg holds:
//      TE_SIZE, MANT_SIZE, PIF_SIZE functions of N, ES;
//      the pif_t packed struct {sign, te, mant}, with field order identical to the ops unpack order.
//  - Sub-module lzc: parameterized leading-zero counter (WIDTH), returning count and all-zero.
//      Regime length is obtained by feeding abs[N-2:0] XOR-ed with abs[N-2] replicated.
//  - Two pipeline register stages with a shared advance enable; no FIFO.
// TESTING  (N=16, ES=1; MANT_SIZE=14, TE_SIZE=6)
//  - 0x4000 -> sign 0, te 0, mant 0x2000; 0x4800 -> te 0, mant 0x3000; 0x5000 -> te 1, mant 0x2000.
//  - 0x7FFF -> te 28, mant 0x2000; 0x0001 -> te -28, mant 0x2000; 0xC000 -> sign 1, te 0, mant 0x2000.
//  - 0x0000 -> is_zero 1, out_pif 0; 0x8000 -> is_nar 1, out_pif 0.
//  - Back-to-back 0x4000, 0x5000, 0x7FFF with out_ready low cycles 3-5:
//      outputs held stable, then emitted in order, no loss/dup; in_ready low while stalled.
//  - rst pulsed with 2 words in flight -> out_valid 0 next cycle, in_ready 1, no stale output ever appears.
//  - PPU_DECODE_STATS_EN: 5 words incl. 2 NaR -> stat_count 5, stat_nar 2.
//      Saturation checked by forcing the counter to 0xFFFE and sending 3 words -> 0xFFFF.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared posit/PIF definitions for the posit processing unit.
// Field widths of the PIF operand word are derived from the posit width N and
// the exponent field width ES; pif_t is laid out in the same order the ops
// stage unpacks it: {sign, te, mant}.
package ppu_pkg;

    // Signed total-exponent width: room for k*2^ES plus the exponent field.
    function automatic int te_size(input int n, input int es);
        return es + $clog2(n) + 1;
    endfunction

    // Mantissa includes the hidden leading one.
    function automatic int mant_size(input int n);
        return n - 2;
    endfunction

    function automatic int pif_size(input int n, input int es);
        return 1 + te_size(n, es) + mant_size(n);
    endfunction

    localparam int N_DEFAULT  = 16;
    localparam int ES_DEFAULT = 1;
    localparam int TE_SIZE    = te_size(N_DEFAULT, ES_DEFAULT);
    localparam int MANT_SIZE  = mant_size(N_DEFAULT);
    localparam int PIF_SIZE   = pif_size(N_DEFAULT, ES_DEFAULT);

    typedef struct packed {
        logic                 sign;
        logic [TE_SIZE-1:0]   te;
        logic [MANT_SIZE-1:0] mant;
    } pif_t;

endpackage

// File: rtl/posit_decode_pipe_lzc.sv
// Leading-zero counter: count of zeros above the most significant set bit.
// An all-zero input reports count = WIDTH and raises all_zero.
module lzc #(
    parameter  int WIDTH = 15,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [CW-1:0]    count,
    output logic             all_zero
);

    // Scan upwards so the highest set bit has the final say.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign all_zero = (in_vec == '0);

endmodule

// File: rtl/posit_decode_pipe.sv
// Streaming posit-to-PIF decoder, two pipeline stages sharing one advance
// enable. Stage 1 takes the absolute value and flags zero/NaR; stage 2
// decodes regime, exponent and fraction into {sign, te, mant}.
// Optional build macro PPU_DECODE_STATS_EN adds saturating output counters
// (stat_count, stat_nar); the datapath is the same either way.
module posit_decode_pipe
    import ppu_pkg::*;
#(
    parameter  int N      = 16,
    parameter  int ES     = 1,
    localparam int TE_W   = te_size(N, ES),
    localparam int MANT_W = mant_size(N),
    localparam int PIF_W  = pif_size(N, ES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_posit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIF_W-1:0] out_pif,
    output logic             out_is_zero,
    output logic             out_is_nar
`ifdef PPU_DECODE_STATS_EN
    ,
    output logic [15:0]      stat_count,
    output logic [15:0]      stat_nar
`endif
);

    localparam int RW = N - 1;            // body width below the sign bit
    localparam int CW = $clog2(RW + 1);   // regime run-length width
    localparam int FW = RW - 1 - ES;      // fraction bits left after min regime + exponent
    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    logic advance;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_q,  s1_sign_d;
    logic [RW-1:0] s1_body_q,  s1_body_d;
    logic          s1_zero_q,  s1_zero_d;
    logic          s1_nar_q,   s1_nar_d;

    logic             out_valid_q, out_valid_d;
    logic [PIF_W-1:0] out_pif_q,   out_pif_d;
    logic             out_zero_q,  out_zero_d;
    logic             out_nar_q,   out_nar_d;

    // Whole pipe moves together; it only freezes while the output is held.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // Stage 1: sign, magnitude below the sign bit, special-value flags.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_body_d  = s1_body_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_posit[N-1];
                // Low N-1 bits of the two's complement negation.
                s1_body_d = in_posit[N-1] ? (~in_posit[RW-1:0] + RW'(1)) : in_posit[RW-1:0];
                s1_zero_d = (in_posit == '0);
                s1_nar_d  = (in_posit == NAR_WORD);
            end
        end
    end

    // Regime run length: leading zeros of the body with the run bit folded out.
    logic          run_bit;
    logic [RW-1:0] run_vec;
    logic [CW-1:0] run_len;
    logic          run_all;

    assign run_bit = s1_body_q[RW-1];
    assign run_vec = s1_body_q ^ {RW{run_bit}};

    lzc #(.WIDTH(RW)) u_lzc (
        .in_vec   (run_vec),
        .count    (run_len),
        .all_zero (run_all)
    );

    logic [RW-2:0]     rem_bits;
    logic [ES-1:0]     exp_bits;
    logic [FW-1:0]     frac_bits;
    logic [TE_W-1:0]   k_val;
    logic [TE_W-1:0]   te_val;
    logic [MANT_W-1:0] mant_val;
    logic [PIF_W-1:0]  pif_val;

    // Stage 2 decode: drop regime + terminator, then split exponent and fraction.
    always_comb begin
        // Shifting body[RW-2:0] by r equals shifting the body by r+1 (run plus terminator).
        rem_bits  = run_all ? '0 : (s1_body_q[RW-2:0] << run_len);
        exp_bits  = rem_bits[RW-2 -: ES];
        frac_bits = rem_bits[FW-1:0];
        k_val     = run_bit ? (TE_W'(run_len) - TE_W'(1)) : (TE_W'(0) - TE_W'(run_len));
        te_val    = (k_val << ES) + TE_W'(exp_bits);
        mant_val  = MANT_W'({1'b1, frac_bits}) << (MANT_W - 1 - FW);
        pif_val   = {s1_sign_q, te_val, mant_val};
        if (s1_zero_q || s1_nar_q) begin
            pif_val = '0;
        end
    end

    // Output stage: load a decoded word when one is present, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pif_d   = out_pif_q;
        out_zero_d  = out_zero_q;
        out_nar_d   = out_nar_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_pif_d  = pif_val;
                out_zero_d = s1_zero_q;
                out_nar_d  = s1_nar_q;
            end
        end
    end

    // Pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_body_q   <= '0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pif_q   <= '0;
            out_zero_q  <= 1'b0;
            out_nar_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_body_q   <= s1_body_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
            out_valid_q <= out_valid_d;
            out_pif_q   <= out_pif_d;
            out_zero_q  <= out_zero_d;
            out_nar_q   <= out_nar_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pif     = out_pif_q;
    assign out_is_zero = out_zero_q;
    assign out_is_nar  = out_nar_q;

`ifdef PPU_DECODE_STATS_EN
    logic        out_xfer;
    logic [15:0] stat_count_q, stat_count_d;
    logic [15:0] stat_nar_q,   stat_nar_d;

    assign out_xfer = out_valid_q && out_ready;

    // Saturating counts of words leaving on the output handshake.
    always_comb begin
        stat_count_d = stat_count_q;
        stat_nar_d   = stat_nar_q;
        if (out_xfer && (stat_count_q != 16'hFFFF)) begin
            stat_count_d = stat_count_q + 16'd1;
        end
        if (out_xfer && out_nar_q && (stat_nar_q != 16'hFFFF)) begin
            stat_nar_d = stat_nar_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_count_q <= '0;
            stat_nar_q   <= '0;
        end else begin
            stat_count_q <= stat_count_d;
            stat_nar_q   <= stat_nar_d;
        end
    end

    assign stat_count = stat_count_q;
    assign stat_nar   = stat_nar_q;
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe (N=16, ES=1).
// A bit-walking posit model feeds a scoreboard; one negedge process checks
// every output transfer, stall hold and the ready rule.
module tb_posit_decode_pipe;
    import ppu_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in_posit;
    logic                out_valid;
    logic                out_ready;
    logic [PIF_SIZE-1:0] out_pif;
    logic                out_is_zero;
    logic                out_is_nar;
`ifdef PPU_DECODE_STATS_EN
    logic [15:0]         stat_count;
    logic [15:0]         stat_nar;
`endif

    always #5 clk = ~clk;

    posit_decode_pipe #(.N(16), .ES(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_posit    (in_posit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pif     (out_pif),
        .out_is_zero (out_is_zero),
        .out_is_nar  (out_is_nar)
`ifdef PPU_DECODE_STATS_EN
        ,
        .stat_count  (stat_count),
        .stat_nar    (stat_nar)
`endif
    );

    typedef struct packed {
        logic [PIF_SIZE-1:0] pif;
        logic                z;
        logic                n;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [15:0] tx_q[$];
    bit          rdy_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic int bit_at(input int v, input int p);
        return (p >= 0) ? ((v >> p) & 1) : 0;
    endfunction

    // Walk the posit bit by bit: regime run, terminator, exponent, fraction.
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        pif_t p;
        int   a, pos, run, k, ex, m, first;
        e = '0;
        p = '0;
        if (w == 16'h0000) begin e.z = 1'b1; return e; end
        if (w == 16'h8000) begin e.n = 1'b1; return e; end
        p.sign = w[15];
        a      = w[15] ? (65536 - int'(w)) : int'(w);
        first  = bit_at(a, 14);
        pos    = 14;
        run    = 0;
        while (pos >= 0 && bit_at(a, pos) == first) begin
            run++;
            pos--;
        end
        pos--;
        k  = (first == 1) ? run - 1 : -run;
        ex = bit_at(a, pos);
        pos--;
        m  = 1;
        for (int i = 0; i < 13; i++) begin
            m = m * 2 + bit_at(a, pos);
            pos--;
        end
        p.te   = 6'(k * 2 + ex);
        p.mant = 14'(m);
        e.pif  = p;
        return e;
    endfunction

    // Compare process: ready rule, stall hold, scoreboard on each transfer.
    logic                prev_stall = 1'b0;
    logic [PIF_SIZE-1:0] prev_pif;
    logic                prev_z, prev_n;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_pif",   32'(out_pif),   32'(prev_pif));
                check("hold_flags", {30'd0, out_is_zero, out_is_nar}, {30'd0, prev_z, prev_n});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pif %h want no output", out_pif);
                end else begin
                    e = sb.pop_front();
                    check("out_pif",     32'(out_pif),     32'(e.pif));
                    check("out_is_zero", 32'(out_is_zero), 32'(e.z));
                    check("out_is_nar",  32'(out_is_nar),  32'(e.n));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_posit));
            end
            prev_stall = out_valid && !out_ready;
            prev_pif   = out_pif;
            prev_z     = out_is_zero;
            prev_n     = out_is_nar;
        end
    end

    // Drive tx_q with the out_ready pattern in rdy_q; starts and ends just after posedge.
    task automatic run_stream(input int limit);
        int cyc;
        bit acc;
        cyc = 0;
        while ((tx_q.size() > 0 || sb.size() > 0) && cyc < limit) begin
            in_valid  = (tx_q.size() > 0);
            in_posit  = in_valid ? tx_q[0] : 16'h0000;
            out_ready = (cyc < rdy_q.size()) ? rdy_q[cyc] : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) void'(tx_q.pop_front());
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_drained", 32'(tx_q.size() + sb.size()), 32'd0);
        tx_q.delete();
        rdy_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    logic [15:0] pin_w[8] = '{16'h4000, 16'h4800, 16'h5000, 16'h7FFF,
                              16'h0001, 16'hC000, 16'h0000, 16'h8000};
    logic [20:0] pin_p[8] = '{21'h002000, 21'h003000, 21'h006000, 21'h072000,
                              21'h092000, 21'h102000, 21'h000000, 21'h000000};
    logic [1:0]  pin_f[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};

    initial begin
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_posit  = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pif",   32'(out_pif),   32'd0);
        check("rst_flags",     {30'd0, out_is_zero, out_is_nar}, 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Pin the model to hand-computed decodes
        for (int i = 0; i < 8; i++) begin
            e = model(pin_w[i]);
            check($sformatf("model_pif_%h", pin_w[i]),   32'(e.pif), 32'(pin_p[i]));
            check($sformatf("model_flags_%h", pin_w[i]), {30'd0, e.z, e.n}, 32'(pin_f[i]));
        end

        // Latency: one word, out_valid exactly two cycles after acceptance
        @(posedge clk);
        #1 in_valid = 1'b1; in_posit = 16'h4000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_c2", 32'(out_valid), 32'd1);
        check("latency_pif", 32'(out_pif), 32'h002000);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Directed table streamed back to back
        for (int i = 0; i < 8; i++) tx_q.push_back(pin_w[i]);
        run_stream(200);

        // Back-to-back with output stalled in cycles 3-5
        tx_q  = '{16'h4000, 16'h5000, 16'h7FFF};
        rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_stream(200);

        // Mixed words with irregular backpressure
        tx_q  = '{16'hFFFF, 16'h8001, 16'h3FFF, 16'h6A5C, 16'h0800, 16'h7000,
                  16'h8000, 16'h0000, 16'h2345, 16'hB7E1, 16'h7FFE, 16'h0002};
        rdy_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_stream(300);

        // Reset with two words in flight
        in_valid = 1'b1; in_posit = 16'h4000;
        @(posedge clk);
        #1 in_posit = 16'h5000;
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        repeat (6) @(negedge clk);
        check("midrst_quiet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

`ifdef PPU_DECODE_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tx_q = '{16'h4000, 16'h8000, 16'h5000, 16'h8000, 16'h0001};
        run_stream(200);
        @(negedge clk);
        check("stat_count", 32'(stat_count), 32'd5);
        check("stat_nar",   32'(stat_nar),   32'd2);
        @(posedge clk);
        #1 force dut.stat_count_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.stat_count_q;
        tx_q = '{16'h4000, 16'h4800, 16'h5000};
        run_stream(200);
        @(negedge clk);
        check("stat_sat",     32'(stat_count), 32'h0000FFFF);
        check("stat_nar_sat", 32'(stat_nar),   32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
